// File: rtl/gnrl_pkg.sv
// Shared constants for the gnrl_* pipeline helpers.
package gnrl_pkg;
  localparam int GNRL_PIPE_MODE_FWD  = 0;
  localparam int GNRL_PIPE_MODE_SKID = 1;
endpackage

// File: rtl/gnrl_pipe_slice.sv
// One elastic pipeline stage: forward-registered (1 entry) or skid (main + skid entry).
module gnrl_pipe_slice
  import gnrl_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               MODE      = GNRL_PIPE_MODE_FWD,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_dn_valid,
  input  logic             i_dn_ready,
  output logic [WIDTH-1:0] o_dn_data
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  assign o_dn_valid = r_v && !i_flush;
  assign o_dn_data  = r_d;

  generate
    if (MODE == GNRL_PIPE_MODE_SKID) begin : g_skid
      logic             r_sv;
      logic [WIDTH-1:0] r_sd;
      logic             w_up_fire;
      logic             w_main_ld;

      // Ready comes straight from the skid flop, cutting the o_ready->i_ready path.
      assign o_up_ready = !r_sv && !i_flush;
      assign w_up_fire  = i_up_valid && !r_sv && !i_flush;
      assign w_main_ld  = (!r_v || i_dn_ready) && !i_flush;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v  <= 1'b0;
          r_sv <= 1'b0;
        end else if (i_flush) begin
          r_v  <= 1'b0;
          r_sv <= 1'b0;
        end else if (w_main_ld) begin
          r_v  <= r_sv || w_up_fire;
          r_sv <= 1'b0;
        end else if (w_up_fire) begin
          r_sv <= 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_d  <= RESET_VAL;
          r_sd <= RESET_VAL;
        end else begin
          if (w_main_ld && r_sv)           r_d  <= r_sd;
          else if (w_main_ld && w_up_fire) r_d  <= i_up_data;
          if (!w_main_ld && w_up_fire)     r_sd <= i_up_data;
        end
      end
    end else begin : g_fwd
      logic w_load;

      assign w_load     = (!r_v || i_dn_ready) && !i_flush;
      assign o_up_ready = w_load;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_v <= 1'b0;
        else if (i_flush) r_v <= 1'b0;
        else if (w_load)  r_v <= i_up_valid;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_d <= RESET_VAL;
        else if (w_load && i_up_valid) r_d <= i_up_data;
      end
    end
  endgenerate

endmodule

// File: rtl/gnrl_pipe_buf.sv
// Elastic pipeline buffer: DEPTH chained slices with valid/ready at both ends,
// synchronous flush and an occupancy counter.
module gnrl_pipe_buf
  import gnrl_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter int               MODE      = GNRL_PIPE_MODE_FWD,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH:0]            w_vld;
  logic [DEPTH:0][WIDTH-1:0] w_dat;
  // Kept unpacked: in forward mode each bit is a combinational function of the next.
  logic                      w_rdy [DEPTH+1];
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic [CNT_W-1:0]          r_cnt;

  assign w_vld[0]     = i_valid;
  assign w_dat[0]     = i_data;
  assign w_rdy[DEPTH] = o_ready;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slice
      gnrl_pipe_slice #(
        .WIDTH    (WIDTH),
        .MODE     (MODE),
        .RESET_VAL(RESET_VAL)
      ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_up_valid(w_vld[g]),
        .o_up_ready(w_rdy[g]),
        .i_up_data (w_dat[g]),
        .o_dn_valid(w_vld[g+1]),
        .i_dn_ready(w_rdy[g+1]),
        .o_dn_data (w_dat[g+1])
      );
    end
  endgenerate

  assign i_ready    = w_rdy[0] && !rst;
  assign o_valid    = w_vld[DEPTH];
  assign o_data     = w_dat[DEPTH];
  assign w_in_fire  = i_valid && i_ready;
  assign w_out_fire = o_valid && o_ready;
  assign count      = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (flush) r_cnt <= '0;
    else            r_cnt <= r_cnt + CNT_W'(w_in_fire) - CNT_W'(w_out_fire);
  end

endmodule

// File: tb/tb_gnrl_pipe_buf.sv
// Scoreboard bench for gnrl_pipe_buf over four configurations (fwd D3, skid D2, fwd D1, skid D1).
module tb_gnrl_pipe_buf;
  localparam logic [7:0] RV [4] = '{8'hC3, 8'h3C, 8'h5A, 8'hA5};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flush, iv, ordy, irdy, ov;
  logic [7:0] idat [4];
  logic [7:0] odat [4];
  logic [2:0] c0, c1;
  logic [1:0] c2, c3;
  logic [2:0] cnt [4];

  logic [7:0] expq [4][$];
  logic [7:0] obsq [4][$];
  int first_in [4];
  int first_out [4];
  int last_out [4];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cnt[0] = c0;
    cnt[1] = c1;
    cnt[2] = {1'b0, c2};
    cnt[3] = {1'b0, c3};
  end

  gnrl_pipe_buf #(.WIDTH(8), .DEPTH(3), .MODE(0), .RESET_VAL(8'hC3)) u_f3 (
    .clk(clk), .rst(rst), .flush(flush[0]), .i_valid(iv[0]), .i_ready(irdy[0]), .i_data(idat[0]),
    .o_valid(ov[0]), .o_ready(ordy[0]), .o_data(odat[0]), .count(c0));
  gnrl_pipe_buf #(.WIDTH(8), .DEPTH(2), .MODE(1), .RESET_VAL(8'h3C)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush[1]), .i_valid(iv[1]), .i_ready(irdy[1]), .i_data(idat[1]),
    .o_valid(ov[1]), .o_ready(ordy[1]), .o_data(odat[1]), .count(c1));
  gnrl_pipe_buf #(.WIDTH(8), .DEPTH(1), .MODE(0), .RESET_VAL(8'h5A)) u_f1 (
    .clk(clk), .rst(rst), .flush(flush[2]), .i_valid(iv[2]), .i_ready(irdy[2]), .i_data(idat[2]),
    .o_valid(ov[2]), .o_ready(ordy[2]), .o_data(odat[2]), .count(c2));
  gnrl_pipe_buf #(.WIDTH(8), .DEPTH(1), .MODE(1), .RESET_VAL(8'hA5)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush[3]), .i_valid(iv[3]), .i_ready(irdy[3]), .i_data(idat[3]),
    .o_valid(ov[3]), .o_ready(ordy[3]), .o_data(odat[3]), .count(c3));

  // Transfers are sampled on the falling edge, half a cycle before the edge that commits them.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (iv[i] && irdy[i]) begin
          expq[i].push_back(idat[i]);
          if (first_in[i] < 0) first_in[i] = cyc;
        end
        if (ov[i] && ordy[i]) begin
          obsq[i].push_back(odat[i]);
          if (first_out[i] < 0) first_out[i] = cyc;
          last_out[i] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear(input int i);
    expq[i].delete();
    obsq[i].delete();
    first_in[i]  = -1;
    first_out[i] = -1;
    last_out[i]  = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = '0; iv = '0; ordy = '0;
    for (int i = 0; i < 4; i++) begin idat[i] = '0; sb_clear(i); end
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (irdy[i] !== 1'b0) begin n_err++; $display("FAIL reset_irdy[%0d]: got %b want 0", i, irdy[i]); end
      n_vec++; if (ov[i] !== 1'b0) begin n_err++; $display("FAIL reset_ovalid[%0d]: got %b want 0", i, ov[i]); end
      n_vec++; if (odat[i] !== RV[i]) begin n_err++; $display("FAIL reset_odata[%0d]: got %h want %h", i, odat[i], RV[i]); end
      n_vec++; if (cnt[i] !== 3'd0) begin n_err++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt[i]); end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (irdy[i] !== 1'b1) begin n_err++; $display("FAIL post_reset_irdy[%0d]: got %b want 1", i, irdy[i]); end
    end
  endtask

  task automatic test_stream();
    int k = 1, b = 0;
    logic acc;
    sb_clear(0);
    ordy[0] = 1'b1;
    while (k <= 10 && b < 100) begin
      iv[0] = 1'b1; idat[0] = 8'(k);
      @(negedge clk); acc = irdy[0];
      tick(); if (acc) k++; b++;
    end
    iv[0] = 1'b0;
    b = 0;
    while (obsq[0].size() < 10 && b < 50) begin tick(); b++; end
    n_vec++; if (obsq[0].size() != 10) begin n_err++; $display("FAIL stream_beats: got %0d want 10", obsq[0].size()); end
    for (int j = 0; j < obsq[0].size(); j++) begin
      n_vec++; if (obsq[0][j] !== 8'(j + 1)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", j, obsq[0][j], 8'(j + 1)); end
    end
    n_vec++; if (first_out[0] - first_in[0] != 3) begin n_err++; $display("FAIL stream_latency: got %0d want 3", first_out[0] - first_in[0]); end
    n_vec++; if (last_out[0] - first_out[0] != 9) begin n_err++; $display("FAIL stream_gapless: got %0d want 9", last_out[0] - first_out[0]); end
  endtask

  task automatic test_backpressure();
    int k = 0, b = 0;
    logic acc;
    logic [7:0] held;
    sb_clear(0);
    for (int c = 0; c < 12; c++) begin
      ordy[0] = (obsq[0].size() == 0);
      iv[0] = (k < 8); idat[0] = 8'(8'h11 + k);
      @(negedge clk); acc = iv[0] && irdy[0];
      tick(); if (acc) k++;
    end
    n_vec++; if (k != 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", k); end
    n_vec++; if (cnt[0] !== 3'd3) begin n_err++; $display("FAIL bp_count: got %0d want 3", cnt[0]); end
    n_vec++; if (irdy[0] !== 1'b0) begin n_err++; $display("FAIL bp_irdy: got %b want 0", irdy[0]); end
    n_vec++; if (ov[0] !== 1'b1) begin n_err++; $display("FAIL bp_ovalid: got %b want 1", ov[0]); end
    held = odat[0];
    n_vec++; if (held !== 8'h12) begin n_err++; $display("FAIL bp_head: got %h want 12", held); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++; if (odat[0] !== held || ov[0] !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b/%h want 1/%h", ov[0], odat[0], held); end
    end
    ordy[0] = 1'b1;
    while ((k < 8 || obsq[0].size() < 8) && b < 100) begin
      iv[0] = (k < 8); idat[0] = 8'(8'h11 + k);
      @(negedge clk); acc = iv[0] && irdy[0];
      tick(); if (acc) k++; b++;
    end
    iv[0] = 1'b0;
    n_vec++; if (obsq[0].size() != 8) begin n_err++; $display("FAIL bp_beats: got %0d want 8", obsq[0].size()); end
    for (int j = 0; j < obsq[0].size(); j++) begin
      n_vec++; if (obsq[0][j] !== 8'(8'h11 + j)) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", j, obsq[0][j], 8'(8'h11 + j)); end
    end
  endtask

  task automatic test_skid();
    int k = 0, b = 0;
    logic acc, r0;
    sb_clear(1);
    ordy[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      iv[1] = 1'b1; idat[1] = 8'(8'hA0 + k);
      @(negedge clk); acc = irdy[1];
      tick(); if (acc) k++;
    end
    n_vec++; if (k != 4) begin n_err++; $display("FAIL skid_accepted: got %0d want 4", k); end
    n_vec++; if (cnt[1] !== 3'd4) begin n_err++; $display("FAIL skid_count: got %0d want 4", cnt[1]); end
    n_vec++; if (irdy[1] !== 1'b0) begin n_err++; $display("FAIL skid_irdy: got %b want 0", irdy[1]); end
    for (int c = 0; c < 200; c++) begin
      iv[1] = 1'b1; idat[1] = 8'(8'hA0 + k);
      ordy[1] = 1'($urandom_range(0, 1));
      #1; r0 = irdy[1];
      ordy[1] = !ordy[1];
      #1;
      n_vec++; if (irdy[1] !== r0) begin n_err++; $display("FAIL skid_comb_ready: got %b want %b", irdy[1], r0); end
      ordy[1] = !ordy[1];
      @(negedge clk); acc = irdy[1];
      tick(); if (acc) k++;
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    while (obsq[1].size() < k && b < 30) begin tick(); b++; end
    n_vec++; if (obsq[1].size() != k) begin n_err++; $display("FAIL skid_beats: got %0d want %0d", obsq[1].size(), k); end
    for (int j = 0; j < obsq[1].size(); j++) begin
      n_vec++; if (obsq[1][j] !== 8'(8'hA0 + j)) begin n_err++; $display("FAIL skid_data[%0d]: got %h want %h", j, obsq[1][j], 8'(8'hA0 + j)); end
    end
    n_vec++; if (cnt[1] !== 3'd0) begin n_err++; $display("FAIL skid_drain_count: got %0d want 0", cnt[1]); end
  endtask

  task automatic test_flush();
    int k = 0, b = 0;
    logic acc;
    sb_clear(0);
    ordy[0] = 1'b0;
    while (k < 2 && b < 20) begin
      iv[0] = 1'b1; idat[0] = 8'(8'h21 + k);
      @(negedge clk); acc = irdy[0];
      tick(); if (acc) k++; b++;
    end
    iv[0] = 1'b0;
    tick(); tick();
    n_vec++; if (cnt[0] !== 3'd2) begin n_err++; $display("FAIL flush_fill_count: got %0d want 2", cnt[0]); end
    flush[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'hEE; ordy[0] = 1'b1;
    #1;
    n_vec++; if (irdy[0] !== 1'b0) begin n_err++; $display("FAIL flush_irdy: got %b want 0", irdy[0]); end
    n_vec++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL flush_ovalid: got %b want 0", ov[0]); end
    tick();
    flush[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
    #1;
    n_vec++; if (cnt[0] !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", cnt[0]); end
    n_vec++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL flush_ovalid_after: got %b want 0", ov[0]); end
    n_vec++; if (odat[0] !== 8'h21) begin n_err++; $display("FAIL flush_data_kept: got %h want 21", odat[0]); end
    n_vec++; if (obsq[0].size() != 0 || expq[0].size() != 2) begin n_err++; $display("FAIL flush_transfers: got %0d/%0d want 0/2", obsq[0].size(), expq[0].size()); end
    sb_clear(0);
    k = 0; b = 0; ordy[0] = 1'b1;
    while ((k < 3 || obsq[0].size() < 3) && b < 40) begin
      iv[0] = (k < 3); idat[0] = 8'(8'h31 + k);
      @(negedge clk); acc = iv[0] && irdy[0];
      tick(); if (acc) k++; b++;
    end
    iv[0] = 1'b0;
    n_vec++; if (obsq[0].size() != 3) begin n_err++; $display("FAIL flush_after_beats: got %0d want 3", obsq[0].size()); end
    for (int j = 0; j < obsq[0].size(); j++) begin
      n_vec++; if (obsq[0][j] !== 8'(8'h31 + j)) begin n_err++; $display("FAIL flush_after_data[%0d]: got %h want %h", j, obsq[0][j], 8'(8'h31 + j)); end
    end
  endtask

  task automatic test_reset_midstream();
    int b = 0;
    sb_clear(0); sb_clear(1);
    ordy[0] = 1'b1; ordy[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iv[0] = 1'b1; idat[0] = 8'(8'h41 + c);
      iv[1] = 1'b1; idat[1] = 8'(8'h51 + c);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (ov[i] !== 1'b0) begin n_err++; $display("FAIL midrst_ovalid[%0d]: got %b want 0", i, ov[i]); end
      n_vec++; if (odat[i] !== RV[i]) begin n_err++; $display("FAIL midrst_odata[%0d]: got %h want %h", i, odat[i], RV[i]); end
      n_vec++; if (cnt[i] !== 3'd0) begin n_err++; $display("FAIL midrst_count[%0d]: got %0d want 0", i, cnt[i]); end
      n_vec++; if (irdy[i] !== 1'b0) begin n_err++; $display("FAIL midrst_irdy[%0d]: got %b want 0", i, irdy[i]); end
    end
    iv = '0;
    @(negedge clk); #2;
    rst = 1'b0;
    sb_clear(0); sb_clear(1);
    tick();
    n_vec++; if (irdy[0] !== 1'b1 || cnt[0] !== 3'd0) begin n_err++; $display("FAIL midrst_release: got %b/%0d want 1/0", irdy[0], cnt[0]); end
    iv[0] = 1'b1; idat[0] = 8'h77; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    while (obsq[0].size() < 1 && b < 20) begin tick(); b++; end
    n_vec++; if (obsq[0].size() != 1 || expq[0].size() != 1) begin n_err++; $display("FAIL midrst_new_beats: got %0d/%0d want 1/1", obsq[0].size(), expq[0].size()); end
    else begin
      n_vec++; if (obsq[0][0] !== 8'h77) begin n_err++; $display("FAIL midrst_new_data: got %h want 77", obsq[0][0]); end
    end
    ordy[1] = 1'b1;
    tick();
  endtask

  task automatic test_depth1();
    logic [7:0] nd [4];
    logic acc [4];
    int b = 0;
    for (int i = 2; i < 4; i++) begin sb_clear(i); nd[i] = '0; end
    for (int c = 0; c < 1000; c++) begin
      for (int i = 2; i < 4; i++) begin
        iv[i] = 1'($urandom_range(0, 1)); ordy[i] = 1'($urandom_range(0, 1)); idat[i] = nd[i];
      end
      @(negedge clk);
      for (int i = 2; i < 4; i++) acc[i] = iv[i] && irdy[i];
      tick();
      for (int i = 2; i < 4; i++) begin
        if (acc[i]) nd[i] = nd[i] + 8'd1;
        n_vec++; if (int'(cnt[i]) != expq[i].size() - obsq[i].size() || int'(cnt[i]) > i - 1)
          begin n_err++; $display("FAIL d1_count[%0d]: got %0d want %0d", i, cnt[i], expq[i].size() - obsq[i].size()); end
        n_vec++; if (ov[i] !== (cnt[i] != 3'd0)) begin n_err++; $display("FAIL d1_valid_vs_count[%0d]: got %b want %b", i, ov[i], cnt[i] != 3'd0); end
      end
    end
    iv[2] = 1'b0; iv[3] = 1'b0; ordy[2] = 1'b1; ordy[3] = 1'b1;
    while ((obsq[2].size() < expq[2].size() || obsq[3].size() < expq[3].size()) && b < 20) begin tick(); b++; end
    for (int i = 2; i < 4; i++) begin
      n_vec++; if (obsq[i].size() != expq[i].size() || expq[i].size() < 100)
        begin n_err++; $display("FAIL d1_beats[%0d]: got %0d want %0d", i, obsq[i].size(), expq[i].size()); end
      for (int j = 0; j < obsq[i].size() && j < expq[i].size(); j++) begin
        n_vec++; if (obsq[i][j] !== expq[i][j] || obsq[i][j] !== 8'(j))
          begin n_err++; $display("FAIL d1_data[%0d][%0d]: got %h want %h", i, j, obsq[i][j], 8'(j)); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_skid();
    test_flush();
    test_reset_midstream();
    test_depth1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
